alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
// - Decode/issue stage feeding the combinational ALU: takes a decoded-stage instruction plus operand values,
//   produces ALU operands A/B, 4-bit ALU select code, and writeback control.
// - Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides.
// - Sits between register-file read and the execute stage.
// PARAMETERS
// - XLEN  64  operand/result width; ALU is instantiated with N=XLEN
// PORTS
// - clk        in   1      clock, all state on rising edge
// - rst_n      in   1      asynchronous active-low reset
// - flush      in   1      discard all buffered and incoming entries
// - in_valid   in   1      upstream entry valid
// - in_ready   out  1      stage can accept an entry this cycle
// - inst       in   32     RV64 instruction word
// - pc         in   XLEN   instruction address
// - rs1_val    in   XLEN   rs1 register value
// - rs2_val    in   XLEN   rs2 register value
// - out_valid  out  1      head entry valid to execute stage
// - out_ready  in   1      execute stage accepts head entry
// - alu_a      out  XLEN   ALU operand A
// - alu_b      out  XLEN   ALU operand B
// - alu_sel    out  4      ALU select: 0 add,1 sub,2 mul,3 div,4 and,5 or,6 xor,7 geu,8 ltu,11 sll,12 srl,13 sra
// - rd         out  5      destination register
// - wen        out  1      write rd (0 if rd==0 or illegal)
// - illegal    out  1      instruction not decoded
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, alu_a=alu_b=0, alu_sel=0, rd=0, wen=0, illegal=0; buffer EMPTY.
// - Decode (combinational, captured on accept = in_valid & in_ready):
//   LUI: A=0, B=sext(imm[31:12]<<12), sel=0. AUIPC: A=pc, B=same imm, sel=0.
//   OP-IMM funct3 000/100/110/111/011: A=rs1, B=sext(imm12), sel 0/6/5/4/8.
//   OP-IMM 001 (funct6=0) sel=11; 101 funct6=000000 sel=12, 010000 sel=13; B=zext(shamt[5:0]).
//   OP funct7=0000000: 000 add,001 sll,011 sltu(8),100 xor,101 srl,110 or,111 and; funct7=0100000: 000 sub,101 sra.
//   OP shifts: B=rs2_val & 6'h3F zero-extended.
//   Anything else: illegal=1, wen=0, A=B=0, sel=0; entry still flows through (no stall).
// - Skid buffer states EMPTY/ONE/TWO; head drives outputs, out_valid=(state!=EMPTY).
//   EMPTY: accept->ONE. ONE: accept&~pop->TWO; pop&~accept->EMPTY; both->ONE (new entry head next cycle).
//   TWO: pop->ONE (second entry becomes head); no accept possible.
//   pop = out_valid & out_ready. in_ready is registered: 1 unless next state is TWO.
// - Latency: accepted entry visible at out_valid one cycle later; full throughput 1/cycle when out_ready=1.
// - Head outputs held stable while out_valid & ~out_ready.
// - flush: next state EMPTY, in_ready=1 next cycle; a same-cycle accept is discarded; flush beats pop.
// - rst_n low mid-operation: immediate return to reset values, buffered entries lost.
// CONFIGURATION
// - ALU_ISSUE_MULDIV_EN defined: OP funct7=0000001 funct3 000 -> sel=2 (mul), 101 -> sel=3 (divu), A=rs1, B=rs2.
// - Not defined: those encodings decode as illegal; sel 2/3 never issued.
// TESTING
// - Reset then addi x5,x1,-1 (0xFFF08293), rs1=10, out_ready=1 -> next cycle out_valid=1, A=10, B=0xFFFF_FFFF_FFFF_FFFF, sel=0, rd=5, wen=1.
// - sub x3,x1,x2 rs1=7 rs2=9, then sra x4,x1,x2 with rs2=0x47 -> sel=1 then sel=13 with B=7, back-to-back.
// - out_ready=0, push 3 entries -> 2 captured, in_ready=0 after 2nd; release -> entries emerge in order, 3rd accepted.
// - lui x1,0x80000 -> A=0, B=0xFFFF_FFFF_8000_0000; auipc with pc=0x8000_0000 -> A=pc.
// - inst=0x0000_0000 -> illegal=1, wen=0; addi x0,... -> wen=0, illegal=0.
// - TWO state + flush + in_valid same cycle -> next cycle out_valid=0, in_ready=1, nothing issued.
// - mul x1,x2,x3 -> sel=2 with ALU_ISSUE_MULDIV_EN, illegal=1 without.

Source files
------------

// File: rtl/alu_issue.sv
// Decode/issue stage: decodes RV64 ALU ops into operands/select and queues them in a 2-entry skid buffer.
// Latency: 1 cycle accept->out_valid, 1/cycle throughput. Backpressure: registered in_ready drops once both slots fill.
// ALU_ISSUE_MULDIV_EN adds mul (sel 2) / divu (sel 3) decode; undefined leaves those encodings illegal.
module alu_issue #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    output logic [4:0]      rd,
    output logic            wen,
    output logic            illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_OP    = 7'h33;

    localparam logic [3:0] SEL_ADD = 4'd0,  SEL_SUB = 4'd1,  SEL_MUL = 4'd2,  SEL_DIV = 4'd3;
    localparam logic [3:0] SEL_AND = 4'd4,  SEL_OR  = 4'd5,  SEL_XOR = 4'd6,  SEL_LTU = 4'd8;
    localparam logic [3:0] SEL_SLL = 4'd11, SEL_SRL = 4'd12, SEL_SRA = 4'd13;

    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    entry_t head_q, head_d, tail_q, tail_d;
    entry_t dec;
    logic   dec_ill;
    logic   accept, pop;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      funct6;
    logic [XLEN-1:0] imm_i, imm_u, shamt_i, shamt_r;
    logic            unused_rs_fields;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign funct7  = inst[31:25];
    assign funct6  = inst[31:26];
    assign imm_i   = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u   = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign shamt_i = {{(XLEN-6){1'b0}}, inst[25:20]};
    assign shamt_r = {{(XLEN-6){1'b0}}, rs2_val[5:0]};
    // Register specifiers are resolved upstream; only their values arrive here.
    assign unused_rs_fields = ^inst[19:15];

    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
        dec.rd  = inst[11:7];
        case (opcode)
            OPC_LUI:   dec.b = imm_u;
            OPC_AUIPC: begin
                dec.a = pc;
                dec.b = imm_u;
            end
            OPC_OPIMM: begin
                dec.a = rs1_val;
                dec.b = imm_i;
                case (funct3)
                    3'b000: dec.sel = SEL_ADD;
                    3'b100: dec.sel = SEL_XOR;
                    3'b110: dec.sel = SEL_OR;
                    3'b111: dec.sel = SEL_AND;
                    3'b011: dec.sel = SEL_LTU;
                    3'b001: begin
                        dec.b = shamt_i;
                        if (funct6 == 6'b000000) dec.sel = SEL_SLL;
                        else                     dec_ill = 1'b1;
                    end
                    3'b101: begin
                        dec.b = shamt_i;
                        if (funct6 == 6'b000000)      dec.sel = SEL_SRL;
                        else if (funct6 == 6'b010000) dec.sel = SEL_SRA;
                        else                          dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec.a = rs1_val;
                dec.b = rs2_val;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec.sel = SEL_ADD;
                    {7'h00, 3'b001}: begin dec.sel = SEL_SLL; dec.b = shamt_r; end
                    {7'h00, 3'b011}: dec.sel = SEL_LTU;
                    {7'h00, 3'b100}: dec.sel = SEL_XOR;
                    {7'h00, 3'b101}: begin dec.sel = SEL_SRL; dec.b = shamt_r; end
                    {7'h00, 3'b110}: dec.sel = SEL_OR;
                    {7'h00, 3'b111}: dec.sel = SEL_AND;
                    {7'h20, 3'b000}: dec.sel = SEL_SUB;
                    {7'h20, 3'b101}: begin dec.sel = SEL_SRA; dec.b = shamt_r; end
`ifdef ALU_ISSUE_MULDIV_EN
                    {7'h01, 3'b000}: dec.sel = SEL_MUL;
                    {7'h01, 3'b101}: dec.sel = SEL_DIV;
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries still flow downstream, but as a harmless add of zeros.
        if (dec_ill) begin
            dec.a   = '0;
            dec.b   = '0;
            dec.sel = '0;
        end
        dec.illegal = dec_ill;
        dec.wen     = ~dec_ill & (dec.rd != 5'd0);
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                head_d  = dec;
            end
            ONE: begin
                if (accept && pop) begin
                    head_d = dec;
                end else if (accept) begin
                    state_d = TWO;
                    tail_d  = dec;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (pop) begin
                state_d = ONE;
                head_d  = tail_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign alu_a     = head_q.a;
    assign alu_b     = head_q.b;
    assign alu_sel   = head_q.sel;
    assign rd        = head_q.rd;
    assign wen       = head_q.wen;
    assign illegal   = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: instruction-level reference decode plus a queue model of the issue buffer.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid, wen, illegal;
    logic [31:0] inst;
    logic [63:0] pc, rs1_val, rs2_val, alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [4:0]  rd;

    alu_issue #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .rd(rd), .wen(wen), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int f7, input int r2, input int r1, input int f3,
                                        input int rdn, input int opc);
        return (32'(f7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12) |
               (32'(rdn) << 7) | 32'(opc);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [63:0] pcv,
                                        input logic [63:0] r1, input logic [63:0] r2);
        exp_t e;
        logic signed [63:0] si;
        int opc = int'(i[6:0]);
        int f3  = int'(i[14:12]);
        int f7  = int'(i[31:25]);
        int f6  = int'(i[31:26]);
        int s   = -1;
        e.a = 0;
        e.b = 0;
        if (opc == 'h37 || opc == 'h17) begin
            si  = $signed(i & 32'hFFFF_F000);
            e.b = si;
            e.a = (opc == 'h17) ? pcv : 64'd0;
            s   = 0;
        end else if (opc == 'h13) begin
            si  = $signed(i);
            e.a = r1;
            e.b = si >>> 20;
            case (f3)
                0: s = 0;
                4: s = 6;
                6: s = 5;
                7: s = 4;
                3: s = 8;
                1: s = (f6 == 0) ? 11 : -1;
                5: s = (f6 == 0) ? 12 : (f6 == 16) ? 13 : -1;
                default: s = -1;
            endcase
            if (f3 == 1 || f3 == 5) e.b = (64'(i) >> 20) & 64'd63;
        end else if (opc == 'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 0) begin
                case (f3)
                    0: s = 0;
                    1: s = 11;
                    3: s = 8;
                    4: s = 6;
                    5: s = 12;
                    6: s = 5;
                    7: s = 4;
                    default: s = -1;
                endcase
            end else if (f7 == 'h20) begin
                s = (f3 == 0) ? 1 : (f3 == 5) ? 13 : -1;
            end
`ifdef ALU_ISSUE_MULDIV_EN
            else if (f7 == 1) begin
                s = (f3 == 0) ? 2 : (f3 == 5) ? 3 : -1;
            end
`endif
            if (s >= 11) e.b = r2 % 64;
        end
        e.ill = (s < 0);
        if (e.ill) begin
            e.a = 0;
            e.b = 0;
            s   = 0;
        end
        e.sel = 4'(s);
        e.rd  = i[11:7];
        e.wen = !e.ill && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 9);
        if (k == 0) r[6:0] = 7'h37;
        else if (k == 1) r[6:0] = 7'h17;
        else if (k <= 4) begin
            r[6:0] = 7'h13;
            if ($urandom_range(0, 1) == 1) r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00;
        end else if (k <= 8) begin
            r[6:0] = 7'h33;
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic drv(input bit v, input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] p, input bit ordy, input bit fl);
        in_valid  = v;
        inst      = i;
        rs1_val   = r1;
        rs2_val   = r2;
        pc        = p;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        exp_t e;
        exp_t h;
        bit   acc, popm;
        @(negedge clk);
        check_eq("out_valid", out_valid, q.size() > 0);
        check_eq("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            h = q[0];
            check_eq("alu_a", alu_a, h.a);
            check_eq("alu_b", alu_b, h.b);
            check_eq("alu_sel", alu_sel, h.sel);
            check_eq("wen", wen, h.wen);
            check_eq("illegal", illegal, h.ill);
            if (!h.ill) check_eq("rd", rd, h.rd);
        end
        acc  = in_valid && (q.size() < 2);
        popm = (q.size() > 0) && out_ready;
        e    = ref_decode(inst, pc, rs1_val, rs2_val);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (popm) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        drv(0, 32'h0, 64'h0, 64'h0, 64'h0, ordy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1);
        #12;
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst in_ready", in_ready, 1);
        check_eq("rst alu_a", alu_a, 0);
        check_eq("rst alu_b", alu_b, 0);
        check_eq("rst alu_sel", alu_sel, 0);
        check_eq("rst rd", rd, 0);
        check_eq("rst wen", wen, 0);
        check_eq("rst illegal", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x5,x1,-1
        drv(1, 32'hFFF0_8293, 64'd10, 64'd0, 64'd0, 1, 0);
        tick();
        check_eq("addi out_valid", out_valid, 1);
        check_eq("addi A", alu_a, 64'd10);
        check_eq("addi B", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("addi sel", alu_sel, 0);
        check_eq("addi rd", rd, 5);
        check_eq("addi wen", wen, 1);

        // sub then sra back-to-back
        drv(1, enc('h20, 2, 1, 0, 3, 'h33), 64'd7, 64'd9, 64'd0, 1, 0);
        tick();
        check_eq("sub sel", alu_sel, 1);
        drv(1, enc('h20, 2, 1, 5, 4, 'h33), 64'd7, 64'h47, 64'd0, 1, 0);
        tick();
        check_eq("sra sel", alu_sel, 13);
        check_eq("sra B", alu_b, 64'd7);
        idle(1);
        tick();

        // Backpressure: three pushes against a stalled consumer
        for (int k = 0; k < 3; k++) begin
            drv(1, enc(0, 0, 1, 0, k + 1, 'h13) | (32'(k + 100) << 20), 64'(k), 64'd0, 64'd0, 0, 0);
            tick();
            if (k == 1) check_eq("full in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        idle(1);
        for (int k = 0; k < 3; k++) tick();

        // lui / auipc
        drv(1, 32'h8000_00B7, 64'd0, 64'd0, 64'd0, 1, 0);
        tick();
        check_eq("lui A", alu_a, 64'd0);
        check_eq("lui B", alu_b, 64'hFFFF_FFFF_8000_0000);
        drv(1, 32'h0000_0117, 64'd0, 64'd0, 64'h8000_0000, 1, 0);
        tick();
        check_eq("auipc A", alu_a, 64'h8000_0000);

        // illegal word and write to x0
        drv(1, 32'h0000_0000, 64'd3, 64'd4, 64'd0, 1, 0);
        tick();
        check_eq("zero illegal", illegal, 1);
        check_eq("zero wen", wen, 0);
        drv(1, 32'h0050_0013, 64'd3, 64'd4, 64'd0, 1, 0);
        tick();
        check_eq("x0 illegal", illegal, 0);
        check_eq("x0 wen", wen, 0);

        // mul x1,x2,x3
        drv(1, enc(1, 3, 2, 0, 1, 'h33), 64'd5, 64'd6, 64'd0, 1, 0);
        tick();
`ifdef ALU_ISSUE_MULDIV_EN
        check_eq("mul sel", alu_sel, 2);
        check_eq("mul illegal", illegal, 0);
`else
        check_eq("mul illegal", illegal, 1);
        check_eq("mul sel", alu_sel, 0);
`endif

        // Fill both slots, then flush with a concurrent push
        for (int k = 0; k < 2; k++) begin
            drv(1, enc(0, 0, 1, 0, 7, 'h13), 64'(k), 64'd0, 64'd0, 0, 0);
            tick();
        end
        drv(1, enc(0, 0, 1, 0, 8, 'h13), 64'd9, 64'd0, 64'd0, 1, 1);
        tick();
        check_eq("flush out_valid", out_valid, 0);
        check_eq("flush in_ready", in_ready, 1);
        idle(1);
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drv($urandom_range(0, 9) < 7, rand_inst(), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
            tick();
        end

        // Asynchronous reset with entries buffered
        for (int k = 0; k < 2; k++) begin
            drv(1, rand_inst(), {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 0, 0);
            tick();
        end
        idle(1);
        rst_n = 1'b0;
        #1;
        check_eq("arst out_valid", out_valid, 0);
        check_eq("arst in_ready", in_ready, 1);
        check_eq("arst alu_a", alu_a, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 200; n++) begin
            drv($urandom_range(0, 1), rand_inst(), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 1), 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
